// File: rtl/peripheral_reader.sv
// Peripheral read responder: PWM shadow readback, debounced buttons, clear-on-read press latches.
// Read data lands 1 clk after read_enable with no stall; optional PERIPH_READ_ERR_EN flags unmapped reads.
module peripheral_reader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_BUTTONS     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            addr,
  input  logic [31:0]            data_in,
  input  logic                   write_enable,
  input  logic                   read_enable,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [31:0]            data_out,
  output logic                   data_valid
`ifdef PERIPH_READ_ERR_EN
  ,
  output logic                   read_err
`endif
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    PFX_PWM  = 3'b001;
  localparam logic [2:0]    PFX_BTN  = 3'b010;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

  logic [2:0]             prefix;
  logic                   addr_unused;
  logic [31:0]            pwm_on_q, pwm_off_q;
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] edge_q, edge_d;
  logic                   edge_clr;
  logic [31:0]            rd_data;
  logic                   rd_unmapped;
  logic [31:0]            data_q;
  logic                   valid_q;

  assign prefix      = addr[31:29];
  assign addr_unused = ^addr[28:1];

  // Write snoop: only the PWM prefix is shadowed; addr[0] picks on/off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_on_q  <= '0;
      pwm_off_q <= '0;
    end else if (write_enable && (prefix == PFX_PWM)) begin
      if (addr[0]) pwm_off_q <= data_in;
      else         pwm_on_q  <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          lvl_d;

    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= DB_STABLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // The level is accepted on the edge where the count reaches DEBOUNCE_CYCLES-1.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = level_q[g];
      case (state_q)
        DB_STABLE: begin
          if (sync2_q[g] != level_q[g]) begin
            state_d = DB_COUNTING;
            cnt_d   = '0;
          end
        end
        DB_COUNTING: begin
          if (sync2_q[g] == level_q[g]) begin
            state_d = DB_STABLE;
            cnt_d   = '0;
          end else if (cnt_inc >= CNT_LAST) begin
            lvl_d   = sync2_q[g];
            state_d = DB_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign level_d[g] = lvl_d;
  end

  // A rise accepted on the clearing edge survives so the next read reports it.
  assign edge_clr = read_enable && (prefix == PFX_BTN) && addr[0];
  assign edge_d   = (edge_clr ? '0 : edge_q) | (level_d & ~level_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      edge_q  <= '0;
    end else begin
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  always_comb begin
    rd_data     = '0;
    rd_unmapped = 1'b0;
    case (prefix)
      PFX_PWM: rd_data = addr[0] ? pwm_off_q : pwm_on_q;
      PFX_BTN: rd_data[NUM_BUTTONS-1:0] = addr[0] ? edge_q : level_q;
      default: begin
        rd_unmapped = 1'b1;
`ifdef PERIPH_READ_ERR_EN
        rd_data = 32'hDEAD_BEEF;
`else
        rd_data = 32'h0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= read_enable;
      if (read_enable) data_q <= rd_data;
    end
  end

`ifdef PERIPH_READ_ERR_EN
  logic read_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) read_err_q <= 1'b0;
    else        read_err_q <= read_enable && rd_unmapped;
  end

  assign read_err = read_err_q;
`else
  logic unmapped_unused;
  assign unmapped_unused = rd_unmapped ^ addr_unused;
`endif

  assign data_out   = data_q;
  assign data_valid = valid_q;

endmodule

// File: tb/tb_peripheral_reader.sv
// Directed bench for peripheral_reader with DEBOUNCE_CYCLES=4: vector table plus button/reset sequences.
module tb_peripheral_reader;

  localparam int NB = 2;
`ifdef PERIPH_READ_ERR_EN
  localparam logic [31:0] UNMAP = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] UNMAP = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   addr;
  logic [31:0]   data_in;
  logic          write_enable;
  logic          read_enable;
  logic [NB-1:0] buttons_raw;
  logic [31:0]   data_out;
  logic          data_valid;
`ifdef PERIPH_READ_ERR_EN
  logic          read_err;
`endif

  int checks = 0;
  int errors = 0;

  peripheral_reader #(.DEBOUNCE_CYCLES(4), .NUM_BUTTONS(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .buttons_raw  (buttons_raw),
    .data_out     (data_out),
    .data_valid   (data_valid)
`ifdef PERIPH_READ_ERR_EN
    ,
    .read_err     (read_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_vld;
    logic        chk_dat;
    logic [31:0] exp_dat;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkv(input logic we, input logic re, input logic [31:0] a,
                               input logic [31:0] wd, input logic ev, input logic cd,
                               input logic [31:0] ed, input logic ee, input string nm);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.wd = wd;
    v.exp_vld = ev; v.chk_dat = cd; v.exp_dat = ed; v.exp_err = ee; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    addr        = a;
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    check({nm, "_vld"}, {31'b0, data_valid}, 32'd1);
    check(nm, data_out, exp);
  endtask

  initial begin
    int hits;
    vecs[0]  = mkv(1, 0, 32'h2000_0000, 32'h64,  0, 0, 32'h0,   0, "wr_on");
    vecs[1]  = mkv(1, 0, 32'h2000_0001, 32'h1F4, 0, 0, 32'h0,   0, "wr_off");
    vecs[2]  = mkv(0, 1, 32'h2000_0000, 32'h0,   1, 1, 32'h64,  0, "rd_on");
    vecs[3]  = mkv(0, 0, 32'h2000_0000, 32'h0,   0, 1, 32'h64,  0, "hold");
    vecs[4]  = mkv(0, 1, 32'h2000_0001, 32'h0,   1, 1, 32'h1F4, 0, "rd_off");
    vecs[5]  = mkv(0, 1, 32'h2000_0000, 32'h0,   1, 1, 32'h64,  0, "b2b_on");
    vecs[6]  = mkv(0, 1, 32'h2000_0001, 32'h0,   1, 1, 32'h1F4, 0, "b2b_off");
    vecs[7]  = mkv(1, 0, 32'h4000_0000, 32'h123, 0, 1, 32'h1F4, 0, "wr_btn_ignored");
    vecs[8]  = mkv(1, 0, 32'h0000_0001, 32'h999, 0, 0, 32'h0,   0, "wr_ram_ignored");
    vecs[9]  = mkv(0, 1, 32'h2000_0001, 32'h0,   1, 1, 32'h1F4, 0, "off_unchanged");
    vecs[10] = mkv(0, 1, 32'h4000_0000, 32'h0,   1, 1, 32'h0,   0, "btn_lvl_idle");
    vecs[11] = mkv(0, 1, 32'h4000_0001, 32'h0,   1, 1, 32'h0,   0, "btn_edge_idle");
    vecs[12] = mkv(1, 1, 32'h2000_0000, 32'hAA,  1, 1, 32'h64,  0, "rw_same_old");
    vecs[13] = mkv(0, 1, 32'h2000_0000, 32'h0,   1, 1, 32'hAA,  0, "rw_after_new");
    vecs[14] = mkv(0, 1, 32'h6000_0000, 32'h0,   1, 1, UNMAP,   1, "unmapped_60");
    vecs[15] = mkv(0, 1, 32'h0000_0000, 32'h0,   1, 1, UNMAP,   1, "unmapped_ram");
    vecs[16] = mkv(1, 0, 32'h2000_0002, 32'h55,  0, 1, UNMAP,   0, "wr_on_hi_addr");
    vecs[17] = mkv(0, 1, 32'h2000_0002, 32'h0,   1, 1, 32'h55,  0, "rd_on_hi_addr");
    vecs[18] = mkv(0, 1, 32'hE000_0001, 32'h0,   1, 1, UNMAP,   1, "unmapped_e0");
    vecs[19] = mkv(0, 0, 32'h0,         32'h0,   0, 1, UNMAP,   0, "idle_hold");

    rst_n        = 1'b0;
    addr         = '0;
    data_in      = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    buttons_raw  = '0;
    repeat (3) tick();
    check("reset_vld", {31'b0, data_valid}, 32'd0);
    check("reset_dat", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      write_enable = vecs[i].we;
      read_enable  = vecs[i].re;
      addr         = vecs[i].a;
      data_in      = vecs[i].wd;
      tick();
      write_enable = 1'b0;
      read_enable  = 1'b0;
      check({vecs[i].name, "_vld"}, {31'b0, data_valid}, {31'b0, vecs[i].exp_vld});
      if (vecs[i].chk_dat) check(vecs[i].name, data_out, vecs[i].exp_dat);
`ifdef PERIPH_READ_ERR_EN
      check({vecs[i].name, "_err"}, {31'b0, read_err}, {31'b0, vecs[i].exp_err});
`endif
    end

    // Held press is accepted; its edge is reported once then cleared.
    buttons_raw = 2'b01;
    repeat (10) tick();
    rd(32'h4000_0000, 32'h1, "press_level");
    rd(32'h4000_0001, 32'h1, "press_edge");
    rd(32'h4000_0001, 32'h0, "press_edge_cleared");

    // A 3-cycle glitch is shorter than the debounce window.
    buttons_raw[1] = 1'b1;
    repeat (3) tick();
    buttons_raw[1] = 1'b0;
    repeat (10) tick();
    rd(32'h4000_0000, 32'h1, "glitch_level");
    rd(32'h4000_0001, 32'h0, "glitch_edge");

    // Clearing reads every cycle while a press is accepted: it must surface exactly once.
    buttons_raw[1] = 1'b1;
    hits = 0;
    addr = 32'h4000_0001;
    read_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (data_valid && data_out[1]) hits++;
    end
    read_enable = 1'b0;
    check("edge_during_clear_hits", hits, 32'd1);
    rd(32'h4000_0000, 32'h3, "both_levels");

    // Re-arm button 0's latch, then reset right after a read.
    buttons_raw = 2'b00;
    repeat (10) tick();
    buttons_raw = 2'b01;
    repeat (10) tick();
    rd(32'h4000_0000, 32'h1, "pre_reset_level");
    rd(32'h2000_0001, 32'h1F4, "pre_reset_off");
    buttons_raw = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_vld", {31'b0, data_valid}, 32'd0);
    check("async_reset_dat", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_no_pulse", {31'b0, data_valid}, 32'd0);
    rd(32'h2000_0000, 32'h0, "post_reset_on");
    rd(32'h2000_0001, 32'h0, "post_reset_off");
    rd(32'h4000_0001, 32'h0, "post_reset_edge");
    rd(32'h4000_0000, 32'h0, "post_reset_level");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
